// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue.
package inst_prefetch_queue_pkg;
  localparam int          DataSize     = 32;
  localparam logic [31:0] DataBusReset = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam int          PC_INC       = 4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/prefetch_fifo_mem.sv
// Register-array FIFO holding {pc, inst} pairs; flush clears pointers and count.
module prefetch_fifo_mem #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch PC owner and prefetch buffer in front of IF_ID.
// Optional PREFETCH_STATS_EN adds saturating event counters.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter  int                DEPTH    = 4,
  parameter  int                DATA_W   = DataSize,
  parameter  logic [DATA_W-1:0] RESET_PC = DATA_W'(DataBusReset),
  localparam int                CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] romAddr,
  input  logic [DATA_W-1:0] romInst,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirectAddr,
  input  logic              locker,
  output logic              instValid,
  output logic [DATA_W-1:0] instOut,
  output logic [DATA_W-1:0] pcOut,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]       statFetch,
  output logic [31:0]       statFlush,
  output logic [31:0]       statStall,
  output logic [31:0]       statEmpty
`endif
);
  logic [DATA_W-1:0]   fetch_pc;
  logic [2*DATA_W-1:0] head;
  logic                push, pop;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^redirectAddr[1:0];

  // redirect overrides both sides; a full queue still refills behind a pop
  assign pop  = instValid & ~locker & ~redirect;
  assign push = ~redirect & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= {redirectAddr[DATA_W-1:2], 2'b00};
    else if (push)     fetch_pc <= fetch_pc + DATA_W'(PC_INC);
  end

  assign romAddr = fetch_pc;

  prefetch_fifo_mem #(.DEPTH(DEPTH), .W(2*DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fetch_pc, romInst}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign instValid = ~empty;
  assign instOut   = empty ? DATA_W'(NOP_INST) : head[DATA_W-1:0];
  assign pcOut     = empty ? '0 : head[2*DATA_W-1:DATA_W];

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      statFetch <= '0;
      statFlush <= '0;
      statStall <= '0;
      statEmpty <= '0;
    end else begin
      if (push)               statFetch <= sat_inc(statFetch);
      if (redirect)           statFlush <= sat_inc(statFlush);
      if (instValid & locker) statStall <= sat_inc(statStall);
      if (empty & ~redirect)  statEmpty <= sat_inc(statEmpty);
    end
  end
`endif
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue; ROM word at address a is (a>>2)+0x100.
module tb_inst_prefetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] romAddr, romInst, redirectAddr, instOut, pcOut;
  logic        redirect, locker, instValid, full, empty;
  logic [2:0]  count;
`ifdef PREFETCH_STATS_EN
  logic [31:0] statFetch, statFlush, statStall, statEmpty;
`endif

  int nassert = 0;
  int nfail   = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  assign romInst = rom(romAddr);

  inst_prefetch_queue #(.DEPTH(4), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .romAddr(romAddr), .romInst(romInst),
    .redirect(redirect), .redirectAddr(redirectAddr), .locker(locker),
    .instValid(instValid), .instOut(instOut), .pcOut(pcOut),
    .count(count), .full(full), .empty(empty)
`ifdef PREFETCH_STATS_EN
    , .statFetch(statFetch), .statFlush(statFlush),
    .statStall(statStall), .statEmpty(statEmpty)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lk);
    reset = 1'b1; redirect = 1'b0; redirectAddr = '0; locker = lk;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [2:0]  mcnt;
    int          pops, cyc;
    logic        lk, mpop, mpush;

    // reset values
    reset = 1'b1; redirect = 1'b0; redirectAddr = '0; locker = 1'b0;
    step(); step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(instValid), 32'd0);
    chk("rst_inst", instOut, 32'h13);
    chk("rst_pc", pcOut, 32'h0);
    chk("rst_romaddr", romAddr, 32'h0);
    chk("rst_count", 32'(count), 32'd0);

    // streaming, one per cycle, count holds at 1
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("str_valid", 32'(instValid), 32'd1);
      chk("str_pc", pcOut, 32'(4 * k));
      chk("str_inst", instOut, 32'h100 + 32'(k));
      chk("str_count", 32'(count), 32'd1);
      chk("str_romaddr", romAddr, 32'(4 * (k + 1)));
    end

    // stall fills to full, fetch PC freezes
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) step();
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_full", 32'(full), 32'd1);
    chk("stall_romaddr", romAddr, 32'h10);
    chk("stall_head", pcOut, 32'h0);
    locker = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("drain_pc", pcOut, 32'(4 * k));
      chk("drain_count", 32'(count), 32'd4);
      step();
    end

    // redirect with count=3, unaligned target
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) step();
    chk("pre_redir_count", 32'(count), 32'd3);
    redirect = 1'b1; redirectAddr = 32'h43; locker = 1'b0;
    step();
    redirect = 1'b0;
    chk("redir_empty", 32'(empty), 32'd1);
    chk("redir_romaddr", romAddr, 32'h40);
    chk("redir_valid", 32'(instValid), 32'd0);
    step();
    chk("redir_head_pc", pcOut, 32'h40);
    chk("redir_head_inst", instOut, 32'h110);

    // redirect and locker together while full
    do_reset(1'b1);
    for (int k = 0; k < 5; k++) step();
    chk("pre_flush_full", 32'(full), 32'd1);
    redirect = 1'b1; redirectAddr = 32'h200;
    step();
    redirect = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(instValid), 32'd0);
    step();
    chk("flush_head_pc", pcOut, 32'h200);
    chk("flush_head_inst", instOut, 32'h180);
    chk("flush_refill_count", 32'(count), 32'd1);

    // address wrap at top of memory
    redirect = 1'b1; redirectAddr = 32'hFFFF_FFF8; locker = 1'b0;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_pc0", pcOut, 32'hFFFF_FFF8);
    chk("wrap_inst0", instOut, 32'h4000_00FE);
    step();
    chk("wrap_pc1", pcOut, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", pcOut, 32'h0);
    chk("wrap_romaddr", romAddr, 32'h4);

    // pointer rotation with random locker against a scoreboard
    redirect = 1'b1; redirectAddr = 32'h1000;
    step();
    redirect = 1'b0;
    step();
    exp_pc = 32'h1000; mcnt = 3'd1; pops = 0; cyc = 0;
    while (pops < 12 && cyc < 200) begin
      chk("rot_valid", 32'(instValid), 32'd1);
      chk("rot_pc", pcOut, exp_pc);
      chk("rot_count", 32'(count), 32'(mcnt));
      lk = 1'($urandom_range(0, 1));
      locker = lk;
      mpop  = ~lk;
      mpush = (mcnt < 3'd4) | mpop;
      if (mpop) begin exp_pc += 32'd4; pops++; end
      if (mpush & ~mpop) mcnt++;
      else if (mpop & ~mpush) mcnt--;
      step();
      cyc++;
    end
    chk("rot_done", 32'(pops), 32'd12);
    locker = 1'b0;

    // asynchronous reset mid-operation
    step();
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(instValid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_romaddr", romAddr, 32'h0);

`ifdef PREFETCH_STATS_EN
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) step();
    locker = 1'b0;
    for (int k = 0; k < 6; k++) step();
    redirect = 1'b1; redirectAddr = 32'h80;
    step(); step();
    redirect = 1'b0;
    chk("stat_fetch", statFetch, 32'd10);
    chk("stat_flush", statFlush, 32'd2);
    chk("stat_stall", statStall, 32'd3);
    chk("stat_empty", statEmpty, 32'd1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("stat_rst_fetch", statFetch, 32'd0);
    chk("stat_rst_flush", statFlush, 32'd0);
    chk("stat_rst_stall", statStall, 32'd0);
    chk("stat_rst_valid", 32'(instValid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
